// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 burst encodings, error codes and constants used by the burst
// address generator and its strobe helper.
package axi4_globals_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED    = 2'b00,
        BURST_INCR     = 2'b01,
        BURST_WRAP     = 2'b10,
        BURST_RESERVED = 2'b11
    } burst_e;

    typedef enum logic [2:0] {
        SIZE_1B   = 3'd0,
        SIZE_2B   = 3'd1,
        SIZE_4B   = 3'd2,
        SIZE_8B   = 3'd3,
        SIZE_16B  = 3'd4,
        SIZE_32B  = 3'd5,
        SIZE_64B  = 3'd6,
        SIZE_128B = 3'd7
    } size_e;

    typedef enum logic [1:0] {
        ERR_RESERVED_BURST = 2'd0,
        ERR_SIZE_TOO_BIG   = 2'd1,
        ERR_BAD_WRAP_LEN   = 2'd2,
        ERR_CROSS_4K       = 2'd3
    } burst_err_e;

    localparam int BOUNDARY_4K = 4096;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_strobe_gen.sv
// Byte-lane strobe for one beat: lanes from the beat address up to the end of
// its size-aligned container within the data bus.
module axi4_strobe_gen #(
    parameter int DATA_WIDTH = 32,
    localparam int STRB_W = DATA_WIDTH / 8,
    localparam int OFF_W = (STRB_W > 1) ? $clog2(STRB_W) : 1
) (
    input  logic [OFF_W-1:0]  addr_low,
    input  logic [2:0]        size,
    output logic [STRB_W-1:0] strb
);

    int nbytes;
    int lo_lane;
    int hi_lane;

    always_comb begin
        nbytes  = 1 << size;
        lo_lane = int'(addr_low) % STRB_W;
        hi_lane = (lo_lane & ~(nbytes - 1)) + nbytes - 1;
        strb    = '0;
        for (int i = 0; i < STRB_W; i++) begin
            strb[i] = (i >= lo_lane) && (i <= hi_lane);
        end
    end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// Expands one AXI4 burst command into per-beat address, strobe, index and last,
// rejecting illegal commands with a one-cycle error pulse.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | ready for a command; illegal commands are flagged, stay here
//   ST_BURST | presenting beats; returns to ST_IDLE on the last handshake
module axi4_burst_addr_gen
    import axi4_globals_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 16,
    parameter bit CHECK_4K      = 1'b1
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ID_WIDTH-1:0]       cmd_id,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [2:0]                cmd_size,
    input  logic [1:0]                cmd_burst,
    output logic                      beat_valid,
    input  logic                      beat_ready,
    output logic [ID_WIDTH-1:0]       beat_id,
    output logic [ADDRESS_WIDTH-1:0]  beat_addr,
    output logic [DATA_WIDTH/8-1:0]   beat_strb,
    output logic [7:0]                beat_idx,
    output logic                      beat_last,
    output logic                      err_valid,
    output logic [1:0]                err_code
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));
    localparam logic [ADDRESS_WIDTH-1:0] ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE, ST_BURST} state_e;

    state_e                     state_q, state_d;
    logic [ID_WIDTH-1:0]        id_q;
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic [ADDRESS_WIDTH-1:0]   wrap_lo_q;
    logic [ADDRESS_WIDTH-1:0]   wrap_hi_q;
    logic [7:0]                 len_q;
    logic [7:0]                 idx_q;
    logic [2:0]                 size_q;
    burst_e                     burst_q;
    logic                       err_valid_q;
    burst_err_e                 err_code_q;

    logic                       cmd_accept;
    logic                       beat_hs;
    logic                       is_last;
    burst_e                     cmd_burst_e;
    logic [ADDRESS_WIDTH-1:0]   cmd_bytes;
    logic [ADDRESS_WIDTH-1:0]   cmd_aligned;
    logic [ADDRESS_WIDTH-1:0]   cmd_total;
    logic [ADDRESS_WIDTH-1:0]   cmd_wrap_lo;
    logic [17:0]                span_4k;
    logic                       cmd_illegal;
    burst_err_e                 cmd_err;
    logic [ADDRESS_WIDTH-1:0]   cur_bytes;
    logic [ADDRESS_WIDTH-1:0]   cur_step;
    logic [ADDRESS_WIDTH-1:0]   next_addr;
    logic [STRB_W-1:0]          strb_raw;

    assign cmd_accept = cmd_valid && (state_q == ST_IDLE);
    assign beat_hs    = (state_q == ST_BURST) && beat_ready;
    assign is_last    = (idx_q == len_q);

    // Command checker: first matching rule decides the error code.
    always_comb begin
        cmd_burst_e = burst_e'(cmd_burst);
        cmd_bytes   = ONE << cmd_size;
        cmd_aligned = cmd_addr & ~(cmd_bytes - ONE);
        cmd_total   = (ADDRESS_WIDTH'(cmd_len) + ONE) << cmd_size;
        cmd_wrap_lo = cmd_aligned & ~(cmd_total - ONE);
        span_4k     = 18'(cmd_aligned[11:0]) + ((18'(cmd_len) + 18'd1) << cmd_size);
        cmd_illegal = 1'b1;
        cmd_err     = ERR_RESERVED_BURST;
        if (cmd_burst_e == BURST_RESERVED) begin
            cmd_err = ERR_RESERVED_BURST;
        end else if (cmd_size > MAX_SIZE) begin
            cmd_err = ERR_SIZE_TOO_BIG;
        end else if ((cmd_burst_e == BURST_WRAP) && !wrap_len_ok(cmd_len)) begin
            cmd_err = ERR_BAD_WRAP_LEN;
        end else if (CHECK_4K && (cmd_burst_e == BURST_INCR) && (span_4k > 18'(BOUNDARY_4K))) begin
            cmd_err = ERR_CROSS_4K;
        end else begin
            cmd_illegal = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        beat_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_accept && !cmd_illegal) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                beat_valid = 1'b1;
                if (beat_ready && is_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // INCR realigns after an unaligned first beat; WRAP folds back at the upper bound.
    always_comb begin
        cur_bytes = ONE << size_q;
        cur_step  = (addr_q & ~(cur_bytes - ONE)) + cur_bytes;
        next_addr = addr_q;
        case (burst_q)
            BURST_INCR: next_addr = cur_step;
            BURST_WRAP: next_addr = (cur_step == wrap_hi_q) ? wrap_lo_q : cur_step;
            default:    next_addr = addr_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            id_q        <= '0;
            addr_q      <= '0;
            wrap_lo_q   <= '0;
            wrap_hi_q   <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            size_q      <= '0;
            burst_q     <= BURST_FIXED;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_RESERVED_BURST;
        end else begin
            err_valid_q <= cmd_accept && cmd_illegal;
            if (cmd_accept) begin
                if (cmd_illegal) begin
                    err_code_q <= cmd_err;
                end else begin
                    id_q      <= cmd_id;
                    addr_q    <= (cmd_burst_e == BURST_WRAP) ? cmd_aligned : cmd_addr;
                    wrap_lo_q <= cmd_wrap_lo;
                    wrap_hi_q <= cmd_wrap_lo + cmd_total;
                    len_q     <= cmd_len;
                    idx_q     <= '0;
                    size_q    <= cmd_size;
                    burst_q   <= cmd_burst_e;
                end
            end else if (beat_hs && !is_last) begin
                idx_q  <= idx_q + 8'd1;
                addr_q <= next_addr;
            end
        end
    end

    axi4_strobe_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strobe_gen (
        .addr_low (addr_q[OFF_W-1:0]),
        .size     (size_q),
        .strb     (strb_raw)
    );

    assign beat_id   = id_q;
    assign beat_addr = addr_q;
    assign beat_idx  = idx_q;
    assign beat_strb = beat_valid ? strb_raw : '0;
    assign beat_last = beat_valid && is_last;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Scoreboard bench for axi4_burst_addr_gen: a reference model fills expected
// beat/error queues at issue time; a monitor pops and compares on each output.
module tb_axi4_burst_addr_gen;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 16;
    localparam int SW = DW / 8;

    logic          aclk;
    logic          areset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IW-1:0] cmd_id;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic [1:0]    cmd_burst;
    logic          beat_valid;
    logic          beat_ready;
    logic [IW-1:0] beat_id;
    logic [AW-1:0] beat_addr;
    logic [SW-1:0] beat_strb;
    logic [7:0]    beat_idx;
    logic          beat_last;
    logic          err_valid;
    logic [1:0]    err_code;

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [SW-1:0] strb;
        logic [7:0]    idx;
        logic          last;
    } beat_t;

    beat_t      exp_beats[$];
    logic [1:0] exp_errs[$];
    int n_checks = 0;
    int n_errors = 0;
    bit chk_after_last = 1'b0;

    axi4_burst_addr_gen #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .ID_WIDTH      (IW),
        .CHECK_4K      (1'b1)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_id     (cmd_id),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_id    (beat_id),
        .beat_addr  (beat_addr),
        .beat_strb  (beat_strb),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .err_valid  (err_valid),
        .err_code   (err_code)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: beat addresses from the closed-form burst rules.
    task automatic model_cmd(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int unsigned bytes, total, nb;
        logic [AW-1:0] aligned, lower, a, ab;
        int lo, hi;
        beat_t b;
        bytes   = 32'd1 << size;
        nb      = 32'(len) + 32'd1;
        total   = bytes * nb;
        aligned = addr & ~(bytes - 32'd1);
        if (burst == 2'b11) begin
            exp_errs.push_back(2'd0);
        end else if (bytes > SW) begin
            exp_errs.push_back(2'd1);
        end else if (burst == 2'b10 && !(nb == 2 || nb == 4 || nb == 8 || nb == 16)) begin
            exp_errs.push_back(2'd2);
        end else if (burst == 2'b01 && (aligned % 4096) + nb * bytes > 4096) begin
            exp_errs.push_back(2'd3);
        end else begin
            lower = aligned & ~(total - 32'd1);
            for (int unsigned n = 0; n < nb; n++) begin
                if (burst == 2'b00)      a = addr;
                else if (burst == 2'b01) a = (n == 0) ? addr : aligned + n * bytes;
                else                     a = lower + ((aligned - lower + n * bytes) % total);
                ab = a & ~(bytes - 32'd1);
                lo = int'(a[1:0]);
                hi = int'(ab[1:0]) + int'(bytes) - 1;
                for (int lane = 0; lane < SW; lane++) begin
                    b.strb[lane] = (lane >= lo) && (lane <= hi);
                end
                b.id   = id;
                b.addr = a;
                b.idx  = 8'(n);
                b.last = (n == nb - 1);
                exp_beats.push_back(b);
            end
        end
    endtask

    task automatic send(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int guard;
        @(posedge aclk);
        #1;
        cmd_id    = id;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        cmd_burst = burst;
        cmd_valid = 1'b1;
        guard = 0;
        @(negedge aclk);
        while (!cmd_ready && guard < 2000) begin
            @(negedge aclk);
            guard++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready stayed 0, required 1");
        end
        model_cmd(id, addr, len, size, burst);
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int guard;
        guard = 0;
        while ((exp_beats.size() != 0 || exp_errs.size() != 0) && guard < 3000) begin
            @(posedge aclk);
            #1;
            beat_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            guard++;
        end
        if (guard >= 3000) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d beats %0d errs outstanding, required 0",
                     exp_beats.size(), exp_errs.size());
            exp_beats.delete();
            exp_errs.delete();
        end
        @(posedge aclk);
        #1;
        beat_ready = 1'b1;
    endtask

    // Monitor: compares every handshaken beat and every error pulse.
    initial begin
        beat_t e;
        forever begin
            @(negedge aclk);
            if (areset) begin
                chk_after_last = 1'b0;
                continue;
            end
            if (chk_after_last) begin
                check("ready_after_last", {cmd_ready, beat_valid}, 2'b10);
                chk_after_last = 1'b0;
            end
            if (beat_valid && beat_ready) begin
                if (exp_beats.size() == 0) begin
                    check("unexpected_beat", 64'(beat_idx) + 64'd1, 64'd0);
                end else begin
                    e = exp_beats.pop_front();
                    check("beat{id,addr,strb,idx,last}",
                          {beat_id, beat_addr, beat_strb, beat_idx, beat_last},
                          {e.id, e.addr, e.strb, e.idx, e.last});
                end
                if (beat_last) chk_after_last = 1'b1;
            end
            if (err_valid) begin
                if (exp_errs.size() == 0) begin
                    check("unexpected_err", 64'(err_code) + 64'd1, 64'd0);
                end else begin
                    check("err_code", err_code, exp_errs.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0]    wl [4];
        logic [1:0]    r_burst;
        logic [2:0]    r_size;
        logic [7:0]    r_len;
        logic [AW-1:0] r_addr;
        int            guard;
        wl = '{8'd1, 8'd3, 8'd7, 8'd15};

        areset     = 1'b1;
        cmd_valid  = 1'b0;
        cmd_id     = '0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_size   = '0;
        cmd_burst  = '0;
        beat_ready = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("reset_ctrl{cmd_ready,beat_valid,beat_last,err_valid}",
              {cmd_ready, beat_valid, beat_last, err_valid}, 4'b1000);
        check("reset_data{addr,strb,idx,id}", {beat_addr, beat_strb, beat_idx, beat_id}, 64'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;

        send(16'h0001, 32'h0000_1000, 8'd3, 3'd2, 2'b01); drain(1'b0);
        send(16'h0002, 32'h0000_1008, 8'd3, 3'd2, 2'b10); drain(1'b0);
        send(16'h0003, 32'h0000_2002, 8'd1, 3'd0, 2'b00); drain(1'b0);
        send(16'h0004, 32'h0000_1001, 8'd1, 3'd2, 2'b01); drain(1'b0);
        send(16'h0005, 32'h0000_1000, 8'd0, 3'd2, 2'b11); drain(1'b0);
        send(16'h0006, 32'h0000_0FF8, 8'd3, 3'd2, 2'b01); drain(1'b0);
        send(16'h0007, 32'h0000_1000, 8'd2, 3'd2, 2'b10); drain(1'b0);
        send(16'h0008, 32'h0000_1000, 8'd0, 3'd3, 2'b01); drain(1'b0);
        send(16'h0009, 32'h0000_0FF0, 8'd3, 3'd2, 2'b01);
        send(16'h000A, 32'h0000_003C, 8'd15, 3'd2, 2'b10);
        send(16'h000B, 32'hFFFF_FFFE, 8'd1, 3'd1, 2'b01);
        drain(1'b0);

        // Stall on beat 2, then reset in the middle of beat 5.
        send(16'h00C6, 32'h0000_3000, 8'd7, 3'd2, 2'b01);
        guard = 0;
        do begin
            @(negedge aclk);
            guard++;
        end while (!(beat_valid && beat_idx == 8'd1) && guard < 50);
        check("reach_beat1", {beat_valid, beat_idx}, {1'b1, 8'd1});
        @(posedge aclk);
        #1;
        beat_ready = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            check("stall_hold{valid,idx,addr,strb,last}",
                  {beat_valid, beat_idx, beat_addr, beat_strb, beat_last},
                  {1'b1, 8'd2, 32'h0000_3008, 4'hF, 1'b0});
            @(posedge aclk);
        end
        #1;
        beat_ready = 1'b1;
        guard = 0;
        do begin
            @(negedge aclk);
            guard++;
        end while (!(beat_valid && beat_idx == 8'd4) && guard < 50);
        check("reach_beat4", {beat_valid, beat_idx}, {1'b1, 8'd4});
        @(posedge aclk);
        #1;
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check("mid_reset{beat_valid,cmd_ready,err_valid}", {beat_valid, cmd_ready, err_valid}, 3'b010);
        exp_beats.delete();
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (3) @(posedge aclk);

        for (int k = 0; k < 60; k++) begin
            r_burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            r_size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if (r_burst == 2'b10 && $urandom_range(0, 4) != 0) r_len = wl[$urandom_range(0, 3)];
            else if ($urandom_range(0, 9) == 0)                r_len = 8'($urandom_range(0, 255));
            else                                               r_len = 8'($urandom_range(0, 15));
            r_addr = $urandom;
            if ($urandom_range(0, 2) == 0) r_addr[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
            send(16'($urandom), r_addr, r_len, r_size, r_burst);
            if ($urandom_range(0, 1) == 1) drain(1'b1);
        end
        drain(1'b1);
        repeat (3) @(posedge aclk);
        check("queues_empty", 64'(exp_beats.size() + exp_errs.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
